serial_frame_deser: RTL and testbench



---
 rtl/serial_frame_deser.sv | 201 ++++++++++++++++++++
 tb/tb_serial_frame_deser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser.sv
// serial_frame_deser: hunts a serial bit stream for a sync pattern, shifts in
// one DATA_W-bit payload after each sync, and queues finished words in a
// 2-entry buffer drained by a valid/ready handshake. ovf and perr are sticky.
// Define SERIAL_FRAME_DESER_PARITY_EN to expect a trailing even-parity bit per
// frame; without it perr is tied to 0.
module serial_frame_deser #(
  parameter int                DATA_W = 8,
  parameter int                SYNC_W = 8,
  parameter logic [SYNC_W-1:0] SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              locked,
  output logic              ovf,
  output logic              perr
);

  localparam int HC_W = $clog2(SYNC_W + 1);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(SYNC_W);
  localparam logic [HC_W-1:0] HC_DET  = HC_W'(SYNC_W - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);
  // The parity build keeps the whole word to check it on the parity edge;
  // otherwise the last bit goes straight from din into the pushed word.
`ifdef SERIAL_FRAME_DESER_PARITY_EN
  localparam int DREG_W = DATA_W;
`else
  localparam int DREG_W = DATA_W - 1;
`endif

  typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_PAR} state_e;

  state_e              state_q, state_d;
  // Only SYNC_W-1 bits of history are stored: the match always includes din.
  logic [SYNC_W-2:0]   sr_q, sr_d;
  logic [SYNC_W-1:0]   sr_shift;
  logic [HC_W-1:0]     hunt_cnt_q, hunt_cnt_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DREG_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   data_shift;
  logic [DATA_W-1:0]   head_q, head_d;
  logic                head_vld_q, head_vld_d;
  logic [DATA_W-1:0]   tail_q, tail_d;
  logic                tail_vld_q, tail_vld_d;
  logic                locked_q, locked_d;
  logic                ovf_q, ovf_d;
  logic                sync_hit, push, pop, ovf_set;
  logic [DATA_W-1:0]   word;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
  logic                perr_q, perr_d, perr_set;
`endif

  // Next-state for the frame FSM, the two-entry output buffer and the flags.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    hunt_cnt_d = hunt_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    head_d     = head_q;
    head_vld_d = head_vld_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;
    push       = 1'b0;
    word       = '0;
    ovf_set    = 1'b0;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    perr_set   = 1'b0;
    data_shift = {data_q[DATA_W-2:0], din};
`else
    data_shift = {data_q, din};
`endif
    sr_shift   = {sr_q, din};
    // The count guard keeps leftover history from completing a sync early.
    sync_hit   = (sr_shift == SYNC) && (hunt_cnt_q >= HC_DET);

    case (state_q)
      ST_HUNT: begin
        sr_d = sr_shift[SYNC_W-2:0];
        if (hunt_cnt_q != HC_MAX) hunt_cnt_d = hunt_cnt_q + 1'b1;
        if (sync_hit) begin
          state_d    = ST_DATA;
          bit_cnt_d  = '0;
          sr_d       = '0;
          hunt_cnt_d = '0;
        end
      end
      ST_DATA: begin
        data_d    = data_shift[DREG_W-1:0];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BC_LAST) begin
`ifdef SERIAL_FRAME_DESER_PARITY_EN
          state_d    = ST_PAR;
`else
          push       = 1'b1;
          word       = data_shift;
          state_d    = ST_HUNT;
          hunt_cnt_d = '0;
`endif
        end
      end
`ifdef SERIAL_FRAME_DESER_PARITY_EN
      ST_PAR: begin
        if (din == ^data_q) begin
          push = 1'b1;
          word = data_q;
        end else begin
          perr_set = 1'b1;
        end
        state_d    = ST_HUNT;
        hunt_cnt_d = '0;
      end
`endif
      default: begin
        state_d    = ST_HUNT;
        hunt_cnt_d = '0;
      end
    endcase

    // head is what dout shows; tail is the second slot behind it.
    pop = head_vld_q & dout_ready;
    if (pop) begin
      if (tail_vld_q) begin
        head_d = tail_q;
        if (push) tail_d = word;
        else      tail_vld_d = 1'b0;
      end else if (push) begin
        head_d = word;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_d     = word;
        head_vld_d = 1'b1;
      end else if (!tail_vld_q) begin
        tail_d     = word;
        tail_vld_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end

    locked_d = (state_d != ST_HUNT);
    ovf_d    = (ovf_q & ~clr) | ovf_set;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    perr_d   = (perr_q & ~clr) | perr_set;
`endif
  end

  // State and registered outputs; reset discards any partial frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      sr_q       <= '0;
      hunt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      tail_q     <= '0;
      tail_vld_q <= 1'b0;
      locked_q   <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      hunt_cnt_q <= hunt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      tail_q     <= tail_d;
      tail_vld_q <= tail_vld_d;
      locked_q   <= locked_d;
      ovf_q      <= ovf_d;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign dout       = head_q;
  assign dout_valid = head_vld_q;
  assign locked     = locked_q;
  assign ovf        = ovf_q;
`ifdef SERIAL_FRAME_DESER_PARITY_EN
  assign perr       = perr_q;
`else
  assign perr       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser at default parameters (sync A5).
module tb_serial_frame_deser;

`ifdef SERIAL_FRAME_DESER_PARITY_EN
  localparam int LK = 9;
`else
  localparam int LK = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n, din, clr, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, locked, ovf, perr;

  always #5 clk = ~clk;

  serial_frame_deser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .locked     (locked),
    .ovf        (ovf),
    .perr       (perr)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Observes the output side on the falling edge.
  int         lk_cnt, vld_cnt, ovf_cnt;
  logic [7:0] pops[$];
  always @(negedge clk) begin
    if (locked) lk_cnt++;
    if (dout_valid) vld_cnt++;
    if (ovf) ovf_cnt++;
    if (dout_valid && dout_ready) pops.push_back(dout);
  end

  task automatic clr_mon();
    lk_cnt  = 0;
    vld_cnt = 0;
    ovf_cnt = 0;
    pops.delete();
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (i < pops.size()) return {24'h0, pops[i]};
    return 32'hDEAD;
  endfunction

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] pl);
    send_byte(8'hA5);
    send_byte(pl);
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    send_bit(^pl);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b0);
  endtask

  logic [7:0] hist;
  logic       rb;

  initial begin
    rst_n = 1'b0; din = 1'b0; clr = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dout", dout, 0);
    check_eq("rst_valid", dout_valid, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_perr", perr, 0);
    rst_n = 1'b1;

    // Single frame, consumer always ready.
    dout_ready = 1'b1;
    clr_mon();
    send_frame(8'h3C);
    check_eq("t1_valid", dout_valid, 1);
    check_eq("t1_dout", dout, 32'h3C);
    send_bit(1'b0);
    check_eq("t1_valid_drop", dout_valid, 0);
    check_eq("t1_locked_cycles", lk_cnt, LK);
    check_eq("t1_valid_cycles", vld_cnt, 1);
    check_eq("t1_pop_count", pops.size(), 1);

    // Random idle bits with every A5 window broken up.
    hist = 8'h00;
    clr_mon();
    for (int i = 0; i < 200; i++) begin
      rb = 1'($urandom_range(0, 1));
      if ({hist[6:0], rb} == 8'hA5) rb = ~rb;
      hist = {hist[6:0], rb};
      send_bit(rb);
    end
    check_eq("t2_locked", lk_cnt, 0);
    check_eq("t2_valid", vld_cnt, 0);
    check_eq("t2_ovf", ovf_cnt, 0);

    // Three frames into a stalled buffer: third one overflows.
    dout_ready = 1'b0;
    idle(8);
    clr_mon();
    send_frame(8'h11);
    send_frame(8'h22);
    send_frame(8'h33);
    check_eq("t3_ovf_set", ovf, 1);
    check_eq("t3_valid_full", dout_valid, 1);
    check_eq("t3_head", dout, 32'h11);
    dout_ready = 1'b1;
    idle(3);
    check_eq("t3_pop_count", pops.size(), 2);
    check_eq("t3_pop0", pop_at(0), 32'h11);
    check_eq("t3_pop1", pop_at(1), 32'h22);
    check_eq("t3_empty", dout_valid, 0);
    check_eq("t3_dout_hold", dout, 32'h22);
    check_eq("t3_ovf_sticky", ovf, 1);
    clr = 1'b1;
    send_bit(1'b0);
    clr = 1'b0;
    check_eq("t3_ovf_clr", ovf, 0);

    // Payload equal to SYNC followed directly by another frame.
    idle(8);
    clr_mon();
    send_frame(8'hA5);
    send_frame(8'h5A);
    idle(2);
    check_eq("t4_pop_count", pops.size(), 2);
    check_eq("t4_pop0", pop_at(0), 32'hA5);
    check_eq("t4_pop1", pop_at(1), 32'h5A);
    check_eq("t4_locked_cycles", lk_cnt, 2 * LK);

    // Reset in the middle of a payload with a word waiting in the buffer.
    dout_ready = 1'b0;
    idle(8);
    send_frame(8'h77);
    check_eq("t5_pre_valid", dout_valid, 1);
    send_byte(8'hA5);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    check_eq("t5_pre_locked", locked, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_dout", dout, 0);
    check_eq("t5_rst_valid", dout_valid, 0);
    check_eq("t5_rst_locked", locked, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;
    clr_mon();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    idle(8);
    send_frame(8'h96);
    idle(2);
    check_eq("t5_pop_count", pops.size(), 1);
    check_eq("t5_pop0", pop_at(0), 32'h96);
    check_eq("t5_locked_cycles", lk_cnt, LK);

`ifdef SERIAL_FRAME_DESER_PARITY_EN
    // Bad parity drops the word; the next good frame still goes through.
    idle(8);
    clr_mon();
    send_byte(8'hA5);
    send_byte(8'h0F);
    send_bit(1'b1);
    check_eq("t6_perr_set", perr, 1);
    check_eq("t6_no_word", dout_valid, 0);
    send_frame(8'h07);
    idle(2);
    check_eq("t6_pop_count", pops.size(), 1);
    check_eq("t6_pop0", pop_at(0), 32'h07);
    check_eq("t6_perr_sticky", perr, 1);
`else
    check_eq("t6_perr_tied", perr, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
